// File: rtl/vga_pixel_fetch.sv
// VGA-side SRAM client: issues credit-limited word reads, captures the returned words into a
// prefetch FIFO and serves them as two pixels per word in raster order.
module vga_pixel_fetch #(
   parameter int unsigned MEM_W           = 36,
   parameter int unsigned PIX_W           = 18,
   parameter int unsigned RD_LAT          = 2,
   parameter int unsigned FIFO_DEPTH      = 16,
   parameter int unsigned LOG_DEPTH       = 4,
   parameter int unsigned WORDS_PER_FRAME = 153600,
   parameter int unsigned LOG_WPF         = 18
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 frame_start,
   output logic                 vga_flag,
   input  logic                 done_vga,
   input  logic [MEM_W-1:0]     vga_word,
   input  logic                 pix_pop,
   output logic                 pix_valid,
   output logic [PIX_W-1:0]     pix_out,
   output logic [LOG_DEPTH:0]   fifo_level,
   output logic                 underflow
);

   localparam int unsigned CW = LOG_DEPTH + 2;
   localparam logic [LOG_DEPTH:0] FULL = (LOG_DEPTH+1)'(FIFO_DEPTH);

   logic [MEM_W-1:0]   mem_q [FIFO_DEPTH];
   logic [LOG_DEPTH:0] wr_ptr_q, wr_ptr_d;
   logic [LOG_DEPTH:0] rd_ptr_q, rd_ptr_d;
   logic [RD_LAT-1:0]  inflight_q, inflight_d;
   logic [LOG_WPF-1:0] req_cnt_q, req_cnt_d;
   logic               sel_q, sel_d;
   logic               underflow_q, underflow_d;

   logic [CW-1:0]      inflight_cnt;
   logic               accept, push, wr_en, pop_pix, pop_word;
   logic [MEM_W-1:0]   head;

   // Credit counts words already queued plus words still travelling back from the arbiter,
   // so a returning word always finds a free slot.
   always_comb begin
      inflight_cnt = '0;
      for (int unsigned i = 0; i < RD_LAT; i++)
         inflight_cnt = inflight_cnt + CW'(inflight_q[i]);
   end

   assign fifo_level = wr_ptr_q - rd_ptr_q;
   assign pix_valid  = (fifo_level != '0);
   assign vga_flag   = !reset && !frame_start
                       && ((CW'(fifo_level) + inflight_cnt) < CW'(FIFO_DEPTH))
                       && (req_cnt_q < LOG_WPF'(WORDS_PER_FRAME));
   assign accept     = vga_flag && done_vga;
   assign push       = inflight_q[RD_LAT-1];
   assign wr_en      = push && !frame_start;
   assign head       = mem_q[rd_ptr_q[LOG_DEPTH-1:0]];
   assign pix_out    = pix_valid ? (sel_q ? head[PIX_W-1:0] : head[MEM_W-1:PIX_W]) : '0;
   assign pop_pix    = pix_pop && pix_valid;
   assign pop_word   = pop_pix && sel_q;
   assign underflow  = underflow_q;

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      inflight_d  = inflight_q;
      req_cnt_d   = req_cnt_q;
      sel_d       = sel_q;
      underflow_d = 1'b0;
      if (frame_start) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         inflight_d = '0;
         req_cnt_d  = '0;
         sel_d      = 1'b0;
      end else begin
         inflight_d[0] = accept;
         for (int unsigned i = 1; i < RD_LAT; i++)
            inflight_d[i] = inflight_q[i-1];
         if (accept)   req_cnt_d = req_cnt_q + 1'b1;
         if (push)     wr_ptr_d  = wr_ptr_q + 1'b1;
         if (pop_word) rd_ptr_d  = rd_ptr_q + 1'b1;
         if (pop_pix)  sel_d     = !sel_q;
         underflow_d = pix_pop && !pix_valid;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         inflight_q  <= '0;
         req_cnt_q   <= '0;
         sel_q       <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         inflight_q  <= inflight_d;
         req_cnt_q   <= req_cnt_d;
         sel_q       <= sel_d;
         underflow_q <= underflow_d;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset && wr_en)
         mem_q[wr_ptr_q[LOG_DEPTH-1:0]] <= vga_word;
   end

   a_no_overflow: assert property (@(posedge clock) disable iff (reset)
      !(wr_en && (fifo_level == FULL) && !pop_word));

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Randomized scoreboard bench for vga_pixel_fetch against a queue-based reference model.
module tb_vga_pixel_fetch;

   localparam int unsigned WPF    = 40;
   localparam int unsigned RD_LAT = 2;
   localparam int unsigned DEPTH  = 16;
   localparam int unsigned NCYC   = 2400;

   logic        clock = 1'b0;
   logic        reset, frame_start, done_vga, pix_pop;
   logic [35:0] vga_word;
   logic        vga_flag, pix_valid, underflow;
   logic [17:0] pix_out;
   logic [4:0]  fifo_level;

   vga_pixel_fetch #(
      .MEM_W(36), .PIX_W(18), .RD_LAT(RD_LAT), .FIFO_DEPTH(DEPTH), .LOG_DEPTH(4),
      .WORDS_PER_FRAME(WPF), .LOG_WPF(6)
   ) dut (
      .clock(clock), .reset(reset), .frame_start(frame_start), .vga_flag(vga_flag),
      .done_vga(done_vga), .vga_word(vga_word), .pix_pop(pix_pop), .pix_valid(pix_valid),
      .pix_out(pix_out), .fifo_level(fifo_level), .underflow(underflow)
   );

   always #5 clock = ~clock;

   typedef struct {
      int unsigned arr;
      logic [35:0] w;
   } pend_t;

   pend_t       pend[$];
   logic [17:0] exp_pix[$];
   int          n_vec = 0;
   int          n_err = 0;
   int unsigned cyc   = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: every accepted pixel must be the next one the model delivered
   initial begin
      logic [17:0] e;
      forever begin
         @(negedge clock);
         #2;
         if (!reset && pix_valid && pix_pop) begin
            if (exp_pix.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL pix_unexpected: got %0h expected none (cycle %0d)", pix_out, cyc);
            end else begin
               e = exp_pix.pop_front();
               chk("pix_out", 64'(pix_out), 64'(e));
            end
         end
      end
   end

   initial begin
      int unsigned m_words, m_req, ph;
      bit          m_half, m_uf, fs, dv, pp, e_flag, deliver, valid0;
      logic [35:0] junk;
      pend_t       p;

      m_words = 0; m_req = 0; m_half = 0; m_uf = 0;
      reset = 1'b1; frame_start = 1'b0; done_vga = 1'b1; pix_pop = 1'b0; vga_word = '0;
      repeat (3) @(negedge clock);
      #1;
      chk("rst_vga_flag", 64'(vga_flag), 64'd0);
      chk("rst_pix_valid", 64'(pix_valid), 64'd0);
      chk("rst_pix_out", 64'(pix_out), 64'd0);
      chk("rst_level", 64'(fifo_level), 64'd0);
      chk("rst_underflow", 64'(underflow), 64'd0);

      for (int unsigned c = 0; c < NCYC; c++) begin
         @(negedge clock);
         cyc   = c;
         reset = 1'b0;
         ph    = c / 400;
         case (ph)
            0: begin
               if (c < 40) begin dv = 1; pp = 0; fs = 0; end
               else begin
                  dv = ($urandom_range(99) < 80);
                  pp = ($urandom_range(99) < 50);
                  fs = ($urandom_range(99) == 0);
               end
            end
            1: begin
               dv = c[0];
               pp = !c[0];
               fs = (c % 200 == 100);
            end
            2: begin
               dv = ($urandom_range(99) < 30);
               pp = ($urandom_range(99) < 90);
               fs = ($urandom_range(49) == 0);
            end
            3: begin
               dv = 1;
               pp = ($urandom_range(99) < 20);
               fs = ($urandom_range(149) == 0);
            end
            4: begin
               dv = 1;
               pp = ($urandom_range(99) < 60);
               fs = (c % 37 == 0);
            end
            default: begin
               dv = ($urandom_range(99) < 60);
               pp = ($urandom_range(99) < 60);
               fs = ($urandom_range(79) == 0);
            end
         endcase
         if (fs) pp = 0;

         deliver = (pend.size() > 0) && (pend[0].arr == c);
         junk    = {4'($urandom), 32'($urandom)};
         vga_word    = deliver ? pend[0].w : junk;
         frame_start = fs;
         done_vga    = dv;
         pix_pop     = pp;
         #1;

         e_flag = !fs && ((m_words + pend.size()) < DEPTH) && (m_req < WPF);
         chk("vga_flag", 64'(vga_flag), 64'(e_flag));
         chk("fifo_level", 64'(fifo_level), 64'(m_words));
         chk("pix_valid", 64'(pix_valid), 64'(m_words > 0));
         chk("underflow", 64'(underflow), 64'(m_uf));

         if (fs) begin
            m_words = 0; m_req = 0; m_half = 0; m_uf = 0;
            pend.delete();
            exp_pix.delete();
         end else begin
            valid0 = (m_words > 0);
            m_uf   = pp && !valid0;
            if (pp && valid0) begin
               if (m_half) begin m_half = 0; m_words--; end
               else m_half = 1;
            end
            if (deliver) begin
               p = pend.pop_front();
               m_words++;
               exp_pix.push_back(p.w[35:18]);
               exp_pix.push_back(p.w[17:0]);
            end
            if (e_flag && dv) begin
               m_req++;
               p.arr = c + RD_LAT;
               p.w   = {4'($urandom), 32'($urandom)};
               pend.push_back(p);
            end
         end
      end

      @(negedge clock);
      #3;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
